// File: rtl/dma_controller_pkg.sv
// rtl/dma_controller_pkg.sv - shared types and constants for the DMA channel CSR block
//
// Purpose: register codes, CCR/ISR bit offsets, the CCR field struct and the
//          transfer-size helper used by dma_channel_csr and dma_channel_ctx.
// Ports:   none (package).
package dma_controller_pkg;

   localparam int CH_REG_STRIDE = 8;
   localparam int CCR_W         = 15;

   // CSR register codes inside one channel window
   localparam logic [2:0] REG_ISR   = 3'd0;
   localparam logic [2:0] REG_IFCR  = 3'd1;
   localparam logic [2:0] REG_CCR   = 3'd2;
   localparam logic [2:0] REG_CNDTR = 3'd3;
   localparam logic [2:0] REG_CPAR  = 3'd4;
   localparam logic [2:0] REG_CMAR  = 3'd5;

   // ISR flag offsets; IFCR clear bits reuse the same offsets
   localparam int FLG_GIF = 0;
   localparam int FLG_TC  = 1;
   localparam int FLG_HT  = 2;
   localparam int FLG_TE  = 3;

   // CCR bit offsets
   localparam int CCR_EN      = 0;
   localparam int CCR_TCIE    = 1;
   localparam int CCR_HTIE    = 2;
   localparam int CCR_TEIE    = 3;
   localparam int CCR_DIR     = 4;
   localparam int CCR_CIRC    = 5;
   localparam int CCR_PINC    = 6;
   localparam int CCR_MINC    = 7;
   localparam int CCR_PSIZE   = 8;
   localparam int CCR_MSIZE   = 10;
   localparam int CCR_PL      = 12;
   localparam int CCR_MEM2MEM = 14;

   typedef enum logic [1:0] {
      SZ8  = 2'b00,
      SZ16 = 2'b01,
      SZ32 = 2'b10
   } size_e;

   // Field order matches the CCR bit offsets above (MSB first)
   typedef struct packed {
      logic       mem2mem;
      logic [1:0] pl;
      logic [1:0] msize;
      logic [1:0] psize;
      logic       minc;
      logic       pinc;
      logic       circ;
      logic       dir;
      logic       teie;
      logic       htie;
      logic       tcie;
      logic       en;
   } ccr_t;

   // Address step in bytes; the reserved code 11 behaves like 32-bit
   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      case (size_e'(sz))
         SZ8:     return 3'd1;
         SZ16:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/dma_channel_ctx.sv
// rtl/dma_channel_ctx.sv - one DMA channel: CCR/CNDTR/CPAR/CMAR, live counters, flags, irq
//
// Purpose: holds a single channel's programmed registers, the live remaining
//          count and current addresses, and the TC/HT/TE flags with irq.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   i_wdata                 CSR write data
//   i_wr_ccr/cndtr/cpar/cmar/ifcr  decoded write strobes for this channel
//   i_done, i_err           engine beat-complete / bus-error pulses
//   o_ccr                   live CCR
//   o_ndt                   live remaining count
//   o_cpar, o_cmar          programmed addresses
//   o_paddr, o_maddr        current addresses
//   o_isr                   {TEIF, HTIF, TCIF, GIF}
//   o_irq                   registered interrupt
module dma_channel_ctx
   import dma_controller_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int NDT_W  = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_wr_ccr,
   input  logic              i_wr_cndtr,
   input  logic              i_wr_cpar,
   input  logic              i_wr_cmar,
   input  logic              i_wr_ifcr,
   input  logic              i_done,
   input  logic              i_err,
   output ccr_t              o_ccr,
   output logic [NDT_W-1:0]  o_ndt,
   output logic [ADDR_W-1:0] o_cpar,
   output logic [ADDR_W-1:0] o_cmar,
   output logic [ADDR_W-1:0] o_paddr,
   output logic [ADDR_W-1:0] o_maddr,
   output logic [3:0]        o_isr,
   output logic              o_irq
);

   ccr_t              r_ccr,   w_ccr_n;
   logic [NDT_W-1:0]  r_cndtr, w_cndtr_n;
   logic [NDT_W-1:0]  r_ndt,   w_ndt_n;
   logic [ADDR_W-1:0] r_cpar,  w_cpar_n;
   logic [ADDR_W-1:0] r_cmar,  w_cmar_n;
   logic [ADDR_W-1:0] r_paddr, w_paddr_n;
   logic [ADDR_W-1:0] r_maddr, w_maddr_n;
   logic              r_tcif, r_htif, r_teif, r_irq;
   logic              w_tc_set, w_ht_set, w_te_set;
   logic              w_tc_clr, w_ht_clr, w_te_clr;
   logic [NDT_W-1:0]  w_ndt_dec;

   always_comb begin
      w_ccr_n   = r_ccr;
      w_cndtr_n = r_cndtr;
      w_ndt_n   = r_ndt;
      w_cpar_n  = r_cpar;
      w_cmar_n  = r_cmar;
      w_paddr_n = r_paddr;
      w_maddr_n = r_maddr;
      w_tc_set  = 1'b0;
      w_ht_set  = 1'b0;
      w_te_set  = 1'b0;
      w_ndt_dec = r_ndt - 1'b1;

      if (r_ccr.en) begin
         if (i_err) begin
            // error wins over a simultaneous done: counters stay frozen
            w_te_set   = 1'b1;
            w_ccr_n.en = 1'b0;
         end else if (i_done) begin
            w_ndt_n = w_ndt_dec;
            if (r_ccr.pinc) w_paddr_n = r_paddr + ADDR_W'(size_bytes(r_ccr.psize));
            if (r_ccr.minc) w_maddr_n = r_maddr + ADDR_W'(size_bytes(r_ccr.msize));
            if ((w_ndt_dec == (r_cndtr >> 1)) && (r_cndtr != NDT_W'(1))) w_ht_set = 1'b1;
            if (w_ndt_dec == '0) begin
               w_tc_set = 1'b1;
               if (r_ccr.circ) begin
                  w_ndt_n   = r_cndtr;
                  w_paddr_n = r_cpar;
                  w_maddr_n = r_cmar;
               end else begin
                  w_ccr_n.en = 1'b0;
               end
            end
         end
         // while running only EN is writable
         if (i_wr_ccr && !i_wdata[CCR_EN]) w_ccr_n.en = 1'b0;
      end else begin
         if (i_wr_ccr) begin
            w_ccr_n = ccr_t'(i_wdata[CCR_W-1:0]);
            if (i_wdata[CCR_EN]) begin
               if (r_cndtr == '0) begin
                  w_ccr_n.en = 1'b0;
               end else begin
                  w_ndt_n   = r_cndtr;
                  w_paddr_n = r_cpar;
                  w_maddr_n = r_cmar;
               end
            end
         end
         if (i_wr_cndtr) begin
            w_cndtr_n = i_wdata[NDT_W-1:0];
            w_ndt_n   = i_wdata[NDT_W-1:0];
         end
         if (i_wr_cpar) w_cpar_n = i_wdata[ADDR_W-1:0];
         if (i_wr_cmar) w_cmar_n = i_wdata[ADDR_W-1:0];
      end

      // CGIF clears every flag of the channel
      w_tc_clr = i_wr_ifcr & (i_wdata[FLG_GIF] | i_wdata[FLG_TC]);
      w_ht_clr = i_wr_ifcr & (i_wdata[FLG_GIF] | i_wdata[FLG_HT]);
      w_te_clr = i_wr_ifcr & (i_wdata[FLG_GIF] | i_wdata[FLG_TE]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ccr   <= '0;
         r_cndtr <= '0;
         r_ndt   <= '0;
         r_cpar  <= '0;
         r_cmar  <= '0;
         r_paddr <= '0;
         r_maddr <= '0;
         r_tcif  <= 1'b0;
         r_htif  <= 1'b0;
         r_teif  <= 1'b0;
         r_irq   <= 1'b0;
      end else begin
         r_ccr   <= w_ccr_n;
         r_cndtr <= w_cndtr_n;
         r_ndt   <= w_ndt_n;
         r_cpar  <= w_cpar_n;
         r_cmar  <= w_cmar_n;
         r_paddr <= w_paddr_n;
         r_maddr <= w_maddr_n;
         // a hardware set in the same cycle as a clear keeps the flag
         r_tcif  <= (r_tcif & ~w_tc_clr) | w_tc_set;
         r_htif  <= (r_htif & ~w_ht_clr) | w_ht_set;
         r_teif  <= (r_teif & ~w_te_clr) | w_te_set;
         r_irq   <= (r_tcif & r_ccr.tcie) | (r_htif & r_ccr.htie) | (r_teif & r_ccr.teie);
      end
   end

   assign o_ccr   = r_ccr;
   assign o_ndt   = r_ndt;
   assign o_cpar  = r_cpar;
   assign o_cmar  = r_cmar;
   assign o_paddr = r_paddr;
   assign o_maddr = r_maddr;
   assign o_isr   = {r_teif, r_htif, r_tcif, (r_tcif | r_htif | r_teif)};
   assign o_irq   = r_irq;

endmodule

// File: rtl/dma_channel_csr.sv
// rtl/dma_channel_csr.sv - multi-channel DMA CSR block: decode, read mux, channel contexts, arbiter
//
// Purpose: decodes {channel, reg} CSR accesses, instantiates one dma_channel_ctx
//          per channel and arbitrates enabled requesting channels by priority.
// Build option: DMA_RR_ARB_EN - equal-priority ties resolved round-robin after
//          the last granted channel; otherwise the lowest channel index wins.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_csr_addr          {channel, reg[2:0]}
//   i_csr_wr, i_csr_rd  write / read strobes
//   i_csr_wdata         write data
//   o_csr_rdata         read data, valid with o_csr_rvalid (1 cycle after read)
//   i_req               per-channel peripheral request
//   i_xfer_done         per-channel beat-complete pulse
//   i_xfer_err          per-channel bus-error pulse
//   o_grant             registered one-hot grant
//   o_cur_paddr/maddr   current addresses, channel i at [i*ADDR_W +: ADDR_W]
//   o_cur_ccr           live CCR, channel i at [i*15 +: 15]
//   o_irq               per-channel interrupt
module dma_channel_csr
   import dma_controller_pkg::*;
#(
   parameter int CH_NUM = 4,
   parameter int ADDR_W = 32,
   parameter int NDT_W  = 16,
   parameter int DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [$clog2(CH_NUM)+2:0]  i_csr_addr,
   input  logic                       i_csr_wr,
   input  logic                       i_csr_rd,
   input  logic [DATA_W-1:0]          i_csr_wdata,
   output logic [DATA_W-1:0]          o_csr_rdata,
   output logic                       o_csr_rvalid,
   input  logic [CH_NUM-1:0]          i_req,
   input  logic [CH_NUM-1:0]          i_xfer_done,
   input  logic [CH_NUM-1:0]          i_xfer_err,
   output logic [CH_NUM-1:0]          o_grant,
   output logic [CH_NUM*ADDR_W-1:0]   o_cur_paddr,
   output logic [CH_NUM*ADDR_W-1:0]   o_cur_maddr,
   output logic [CH_NUM*CCR_W-1:0]    o_cur_ccr,
   output logic [CH_NUM-1:0]          o_irq
);

   localparam int AW   = $clog2(CH_NUM) + 3;
   localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   logic [AW-1:0]     w_csr_ch;
   logic [2:0]        w_reg;
   logic [CH_NUM-1:0] w_hit;
   logic [CH_NUM-1:0] w_cand;
   logic [CH_NUM-1:0] w_tie;
   logic [CH_NUM-1:0] w_pick;
   logic [CH_W-1:0]   w_pick_idx;
   logic              w_found;
   logic [1:0]        w_max_pl;
   logic              w_rearb;
   logic [DATA_W-1:0] w_rd_val;

   ccr_t              w_ccr   [CH_NUM];
   logic [NDT_W-1:0]  w_ndt   [CH_NUM];
   logic [ADDR_W-1:0] w_cpar  [CH_NUM];
   logic [ADDR_W-1:0] w_cmar  [CH_NUM];
   logic [ADDR_W-1:0] w_paddr [CH_NUM];
   logic [ADDR_W-1:0] w_maddr [CH_NUM];
   logic [3:0]        w_isr   [CH_NUM];

   logic [DATA_W-1:0] r_rdata;
   logic              r_rvalid;
   logic [CH_NUM-1:0] r_grant;

   // channel numbers at or above CH_NUM match no context, so they read 0
   assign w_csr_ch = i_csr_addr >> 3;
   assign w_reg    = i_csr_addr[2:0];

   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      assign w_hit[g] = (w_csr_ch == AW'(g));

      dma_channel_ctx #(
         .ADDR_W (ADDR_W),
         .NDT_W  (NDT_W),
         .DATA_W (DATA_W)
      ) u_ctx (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_wdata    (i_csr_wdata),
         .i_wr_ccr   (i_csr_wr & w_hit[g] & (w_reg == REG_CCR)),
         .i_wr_cndtr (i_csr_wr & w_hit[g] & (w_reg == REG_CNDTR)),
         .i_wr_cpar  (i_csr_wr & w_hit[g] & (w_reg == REG_CPAR)),
         .i_wr_cmar  (i_csr_wr & w_hit[g] & (w_reg == REG_CMAR)),
         .i_wr_ifcr  (i_csr_wr & w_hit[g] & (w_reg == REG_IFCR)),
         .i_done     (i_xfer_done[g]),
         .i_err      (i_xfer_err[g]),
         .o_ccr      (w_ccr[g]),
         .o_ndt      (w_ndt[g]),
         .o_cpar     (w_cpar[g]),
         .o_cmar     (w_cmar[g]),
         .o_paddr    (w_paddr[g]),
         .o_maddr    (w_maddr[g]),
         .o_isr      (w_isr[g]),
         .o_irq      (o_irq[g])
      );

      // memory-to-memory channels request for as long as they are enabled
      assign w_cand[g] = w_ccr[g].en & (i_req[g] | w_ccr[g].mem2mem);

      assign o_cur_paddr[g*ADDR_W +: ADDR_W] = w_paddr[g];
      assign o_cur_maddr[g*ADDR_W +: ADDR_W] = w_maddr[g];
      assign o_cur_ccr[g*CCR_W +: CCR_W]     = w_ccr[g];
   end

   always_comb begin
      w_rd_val = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (w_hit[i]) begin
            case (w_reg)
               REG_ISR:   w_rd_val = DATA_W'(w_isr[i]);
               REG_CCR:   w_rd_val = DATA_W'(w_ccr[i]);
               REG_CNDTR: w_rd_val = DATA_W'(w_ndt[i]);
               REG_CPAR:  w_rd_val = DATA_W'(w_cpar[i]);
               REG_CMAR:  w_rd_val = DATA_W'(w_cmar[i]);
               default:   w_rd_val = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rdata  <= i_csr_rd ? w_rd_val : '0;
         r_rvalid <= i_csr_rd;
      end
   end

   // keep the current grant until its beat ends or it stops being a candidate
   assign w_rearb = (r_grant == '0) || ((r_grant & (i_xfer_done | i_xfer_err)) != '0) ||
                    ((r_grant & ~w_cand) != '0);

`ifdef DMA_RR_ARB_EN
   logic [CH_W-1:0] r_last;
   logic [CH_W-1:0] w_idx;
`endif

   always_comb begin
      w_max_pl   = 2'd0;
      w_tie      = '0;
      w_pick     = '0;
      w_pick_idx = '0;
      w_found    = 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (w_cand[i] && (w_ccr[i].pl > w_max_pl)) w_max_pl = w_ccr[i].pl;
      end
      for (int i = 0; i < CH_NUM; i++) begin
         w_tie[i] = w_cand[i] && (w_ccr[i].pl == w_max_pl);
      end
`ifdef DMA_RR_ARB_EN
      w_idx = '0;
      // scan starts one past the last granted channel and wraps
      for (int k = 1; k <= CH_NUM; k++) begin
         w_idx = CH_W'((int'(r_last) + k) % CH_NUM);
         if (!w_found && w_tie[w_idx]) begin
            w_found    = 1'b1;
            w_pick_idx = w_idx;
         end
      end
`else
      for (int i = 0; i < CH_NUM; i++) begin
         if (!w_found && w_tie[i]) begin
            w_found    = 1'b1;
            w_pick_idx = CH_W'(i);
         end
      end
`endif
      if (w_found) w_pick[w_pick_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant <= '0;
      end else if (w_rearb) begin
         r_grant <= w_pick;
      end
   end

`ifdef DMA_RR_ARB_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= '0;
      end else if (w_rearb && w_found) begin
         r_last <= w_pick_idx;
      end
   end
`endif

   assign o_csr_rdata  = r_rdata;
   assign o_csr_rvalid = r_rvalid;
   assign o_grant      = r_grant;

endmodule
